ltc2387_acq_seq: RTL and testbench
==================================

LTC2387_ACQ_SEQ -- requirements
Module: ltc2387_acq_seq

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 18: ADC sample width, two's complement.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16: width of period and burst-length inputs.
REQ-003 SHALL have parameter MIN_PERIOD, default 13: minimum trigger spacing in clocks (65 ns at 200 MHz).
REQ-004 SHALL have parameter AVG_LOG2_MAX, default 4: maximum averaging exponent.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: maximum clocks from trigger to data.
REQ-006 sys_clk_int  in  1  system clock; all logic on its rising edge.
REQ-007 reset_int_n  in  1  asynchronous, active-low reset.
REQ-008 mode  in  2  00 idle, 01 single, 10 burst, 11 continuous.
REQ-009 start, stop  in  1 each  single-cycle command pulses.
REQ-010 period  in  PERIOD_WIDTH  trigger-to-trigger spacing in clocks.
REQ-011 burst_len  in  PERIOD_WIDTH  output words per burst.
REQ-012 avg_log2  in  3  averaging exponent k; 2^k conversions per output word.
REQ-013 trig_int  out  1  conversion request to ltc2387_interface.
REQ-014 adc_data_out  in  ADC_WIDTH, adc_data_valid  in  1  sample from ltc2387_interface.
REQ-015 m_data  out  ADC_WIDTH, m_valid  out  1, m_ready  in  1, m_last  out  1: output stream.
REQ-016 busy, overrun, timeout_err  out  1 each  status.

Function
REQ-017 SHALL implement states IDLE, TRIG, WAIT_DATA and GAP.
REQ-018 IDLE: on start with mode != 00, SHALL latch mode, period, burst_len and k, clear overrun and timeout_err, and enter TRIG; start with mode 00 SHALL be ignored.
REQ-019 Latched period < MIN_PERIOD SHALL be treated as MIN_PERIOD; burst_len 0 SHALL be treated as 1; k > AVG_LOG2_MAX SHALL be clamped.
REQ-020 TRIG: trig_int SHALL be high for exactly one cycle, the period counter SHALL load (period-1), and the FSM SHALL enter WAIT_DATA.
REQ-021 WAIT_DATA: adc_data_valid SHALL add the sign-extended sample to an (ADC_WIDTH+AVG_LOG2_MAX)-bit accumulator and increment the conversion count.
REQ-022 When the count reaches 2^k, the output word SHALL be accumulator arithmetically shifted right by k, pushed to the output FIFO on the next cycle; accumulator and count SHALL then clear.
REQ-023 After a sample, the FSM SHALL go to IDLE if the run is complete (single: 1 word; burst: burst_len words), otherwise to GAP; continuous mode never completes.
REQ-024 GAP SHALL wait until the period counter reaches 0, then enter TRIG; if it already expired, TRIG SHALL follow in the next cycle, with no overlapping conversions.
REQ-025 With timely data, consecutive trig_int pulses SHALL be exactly max(period, MIN_PERIOD) clocks apart.
REQ-026 adc_data_valid outside WAIT_DATA SHALL be ignored.
REQ-027 No adc_data_valid within TIMEOUT_CYC clocks of trig_int SHALL set timeout_err and return to IDLE, discarding the partial accumulation.
REQ-028 stop SHALL force IDLE on the next edge from any state, discarding the partial accumulation; FIFO contents SHALL be retained.
REQ-029 start and stop in the same cycle: stop SHALL win; start while busy SHALL be ignored.
REQ-030 The output FIFO SHALL be 2 words deep, with valid/ready semantics: a word transfers when m_valid and m_ready are both high; m_data and m_last SHALL be stable while m_valid is high and m_ready is low.
REQ-031 A push to a full FIFO SHALL drop the new word and set overrun (sticky until next accepted start); a pop and a push in the same cycle when full SHALL both succeed.
REQ-032 m_last SHALL be 1 on the final word of single/burst runs and 0 in continuous mode.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 While reset_int_n is low: state IDLE, trig_int 0, m_valid 0, m_last 0, m_data 0, busy 0, overrun 0, timeout_err 0; FIFO, accumulator, counters and latched configuration cleared.
REQ-035 Reset mid-run SHALL abort without emitting a partial word.

Structure
REQ-036 Package ltc2387_pkg SHALL hold the mode and state enumerations and the default ADC_WIDTH/MIN_PERIOD constants.
REQ-037 The 2-deep FIFO SHALL be sub-module ltc2387_out_fifo; the FSM, counters and accumulator stay in ltc2387_acq_seq.

Verification
REQ-038 Single, k=0, sample 0x1FFFF -> one trig_int pulse, one word 0x1FFFF with m_last=1, busy returns to 0.
REQ-039 Single, k=2, samples 4, 8, -4, 0 -> exactly 4 triggers, one word 0x00002.
REQ-040 Burst, burst_len=3, period=20, m_ready=1 -> triggers 20 clocks apart, 3 words, m_last only on the third.
REQ-041 Continuous, period=5, m_ready=0 -> spacing 13, FIFO holds 2 words, overrun=1 after the third word; stop -> IDLE with 2 words still drainable.
REQ-042 Single with adc_data_valid withheld -> timeout_err=1 after 1024 clocks, busy=0, no word.
REQ-043 reset_int_n low during WAIT_DATA at k=3 -> all outputs 0; new start yields a correct average from fresh samples.

Source files
------------

// File: rtl/ltc2387_pkg.sv
// Shared types and default constants for the LTC2387 acquisition sequencer.
package ltc2387_pkg;
   localparam int ADC_WIDTH_DEF  = 18;
   localparam int MIN_PERIOD_DEF = 13;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_BURST  = 2'b10,
      MODE_CONT   = 2'b11
   } acq_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_DATA,
      ST_GAP
   } acq_state_e;
endpackage

// File: rtl/ltc2387_acq_seq_if.sv
// Output sample stream (valid/ready) from the acquisition sequencer.
interface ltc2387_acq_seq_if
   import ltc2387_pkg::*;
#(
   parameter int ADC_WIDTH = ADC_WIDTH_DEF
);
   logic [ADC_WIDTH-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_last;

   modport master (output m_data, m_valid, m_last, input m_ready);
   modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/ltc2387_out_fifo.sv
// Two-entry output FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module ltc2387_out_fifo
   import ltc2387_pkg::*;
#(
   parameter int W = ADC_WIDTH_DEF
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         push_last,
   input  logic         pop_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   output logic         out_last,
   output logic         drop
);
   logic [1:0][W:0] mem_q;
   logic            rd_q, wr_q;
   logic [1:0]      cnt_q;
   logic            pop, push_ok;

   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid && pop_ready;
   assign push_ok   = push && ((cnt_q != 2'd2) || pop);
   assign drop      = push && !push_ok;
   // Gate outputs when empty so stale entries never show on the bus.
   assign out_data  = out_valid ? mem_q[rd_q][W-1:0] : '0;
   assign out_last  = out_valid && mem_q[rd_q][W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= {push_last, push_data};
            wr_q        <= ~wr_q;
         end
         if (pop)
            rd_q <= ~rd_q;
         if (push_ok && !pop)
            cnt_q <= cnt_q + 2'd1;
         else if (pop && !push_ok)
            cnt_q <= cnt_q - 2'd1;
      end
   end
endmodule

// File: rtl/ltc2387_acq_seq.sv
// Acquisition sequencer: paces ADC triggers, averages 2^k samples per word, streams words out.
module ltc2387_acq_seq
   import ltc2387_pkg::*;
#(
   parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
   parameter int PERIOD_WIDTH = 16,
   parameter int MIN_PERIOD   = MIN_PERIOD_DEF,
   parameter int AVG_LOG2_MAX = 4,
   parameter int TIMEOUT_CYC  = 1024
)(
   input  logic                    sys_clk_int,
   input  logic                    reset_int_n,
   input  logic [1:0]              mode,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [PERIOD_WIDTH-1:0] burst_len,
   input  logic [2:0]              avg_log2,
   output logic                    trig_int,
   input  logic [ADC_WIDTH-1:0]    adc_data_out,
   input  logic                    adc_data_valid,
   ltc2387_acq_seq_if.master       m_out,
   output logic                    busy,
   output logic                    overrun,
   output logic                    timeout_err
);
   localparam int ACC_W = ADC_WIDTH + AVG_LOG2_MAX;
   localparam int CNT_W = AVG_LOG2_MAX + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);

   acq_state_e              state_q, state_d;
   acq_mode_e               mode_q;
   logic [PERIOD_WIDTH-1:0] period_q, burst_q, pcnt_q, words_q;
   logic [2:0]              k_q;
   logic [ACC_W-1:0]        acc_q, acc_sum;
   logic [CNT_W-1:0]        cnt_q, cnt_inc;
   logic [TO_W-1:0]         tcnt_q;
   logic                    push_vld, push_last_q;
   logic [ADC_WIDTH-1:0]    push_data_q;
   logic                    start_ok, sample, word_done, run_done, timed_out, fifo_drop;

   assign start_ok  = start && !stop && (state_q == ST_IDLE) && (mode != 2'b00);
   assign sample    = (state_q == ST_WAIT_DATA) && adc_data_valid;
   assign acc_sum   = acc_q + {{AVG_LOG2_MAX{adc_data_out[ADC_WIDTH-1]}}, adc_data_out};
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign word_done = sample && (cnt_inc == (CNT_W'(1) << k_q));
   assign run_done  = word_done && ((mode_q == MODE_SINGLE) ||
                      ((mode_q == MODE_BURST) && (words_q + P_ONE == burst_q)));
   assign timed_out = (state_q == ST_WAIT_DATA) && !adc_data_valid &&
                      (tcnt_q >= TO_W'(TIMEOUT_CYC));

   assign trig_int = (state_q == ST_TRIG);
   assign busy     = (state_q != ST_IDLE);

   always_ff @(posedge sys_clk_int or negedge reset_int_n) begin
      if (!reset_int_n) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop) state_d = ST_IDLE;
      else begin
         unique case (state_q)
            ST_IDLE:      if (start_ok) state_d = ST_TRIG;
            ST_TRIG:      state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: if (timed_out)   state_d = ST_IDLE;
                          else if (sample) state_d = run_done ? ST_IDLE : ST_GAP;
            // Leave one cycle early so the next trigger lands exactly one period later.
            ST_GAP:       if (pcnt_q <= P_ONE) state_d = ST_TRIG;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   // Run configuration, clamped once at start.
   always_ff @(posedge sys_clk_int or negedge reset_int_n) begin
      if (!reset_int_n) begin
         mode_q   <= MODE_IDLE;
         period_q <= '0;
         burst_q  <= '0;
         k_q      <= '0;
      end else if (start_ok) begin
         mode_q   <= acq_mode_e'(mode);
         period_q <= (period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period;
         burst_q  <= (burst_len == '0) ? P_ONE : burst_len;
         k_q      <= (avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : avg_log2;
      end
   end

   always_ff @(posedge sys_clk_int or negedge reset_int_n) begin
      if (!reset_int_n) begin
         pcnt_q  <= '0;
         tcnt_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         words_q <= '0;
      end else begin
         if (state_q == ST_TRIG)  pcnt_q <= period_q - P_ONE;
         else if (pcnt_q != '0)   pcnt_q <= pcnt_q - P_ONE;

         if (state_q == ST_TRIG)           tcnt_q <= TO_W'(1);
         else if (state_q == ST_WAIT_DATA) tcnt_q <= tcnt_q + TO_W'(1);

         if (stop || timed_out || start_ok || word_done) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (sample) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_inc;
         end

         if (start_ok)       words_q <= '0;
         else if (word_done) words_q <= words_q + P_ONE;
      end
   end

   // Completed word is registered here and pushed into the FIFO the following cycle.
   always_ff @(posedge sys_clk_int or negedge reset_int_n) begin
      if (!reset_int_n) begin
         push_vld    <= 1'b0;
         push_data_q <= '0;
         push_last_q <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         push_vld <= word_done;
         if (word_done) begin
            push_data_q <= ADC_WIDTH'($signed(acc_sum) >>> k_q);
            push_last_q <= run_done;
         end
         overrun <= fifo_drop || (overrun && !start_ok);
         if (start_ok)       timeout_err <= 1'b0;
         else if (timed_out) timeout_err <= 1'b1;
      end
   end

   ltc2387_out_fifo #(.W(ADC_WIDTH)) u_fifo (
      .clk       (sys_clk_int),
      .rst_n     (reset_int_n),
      .push      (push_vld),
      .push_data (push_data_q),
      .push_last (push_last_q),
      .pop_ready (m_out.m_ready),
      .out_data  (m_out.m_data),
      .out_valid (m_out.m_valid),
      .out_last  (m_out.m_last),
      .drop      (fifo_drop)
   );
endmodule

// File: tb/tb_ltc2387_acq_seq.sv
// Directed bench for ltc2387_acq_seq with a fixed-latency ADC responder and stream capture.
module tb_ltc2387_acq_seq;
   import ltc2387_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        start = 1'b0, stop = 1'b0;
   logic [15:0] period = 16'd0, burst_len = 16'd0;
   logic [2:0]  avg_log2 = 3'd0;
   logic        trig_int;
   logic [17:0] adc_data_out = 18'd0;
   logic        adc_data_valid = 1'b0;
   logic        busy, overrun, timeout_err;

   ltc2387_acq_seq_if #(.ADC_WIDTH(18)) m_if ();

   ltc2387_acq_seq dut (
      .sys_clk_int    (clk),
      .reset_int_n    (rst_n),
      .mode           (mode),
      .start          (start),
      .stop           (stop),
      .period         (period),
      .burst_len      (burst_len),
      .avg_log2       (avg_log2),
      .trig_int       (trig_int),
      .adc_data_out   (adc_data_out),
      .adc_data_valid (adc_data_valid),
      .m_out          (m_if),
      .busy           (busy),
      .overrun        (overrun),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_err = 0;
   int          cyc = 0;
   int          trig_cyc[$];
   logic [18:0] out_q[$];
   logic [17:0] samp_q[$];
   logic        adc_en = 1'b1;
   int          lat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors and ADC model all act on the falling edge.
   always @(negedge clk) begin
      if (trig_int) trig_cyc.push_back(cyc);
      if (m_if.m_valid && m_if.m_ready) out_q.push_back({m_if.m_last, m_if.m_data});
      adc_data_valid = 1'b0;
      if (!adc_en) lat = 0;
      else begin
         if (lat > 0) begin
            lat = lat - 1;
            if (lat == 0) begin
               adc_data_out   = (samp_q.size() > 0) ? samp_q.pop_front() : 18'd0;
               adc_data_valid = 1'b1;
            end
         end
         if (trig_int) lat = 3;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run(input logic [1:0] md, input int per, input int bl, input int k);
      trig_cyc.delete();
      mode = md; period = 16'(per); burst_len = 16'(bl); avg_log2 = 3'(k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin @(negedge clk); n++; end
      chk(tag, busy, 0);
   endtask

   task automatic wait_trigs(input string tag, input int cnt, input int max_cyc);
      int n = 0;
      while (trig_cyc.size() < cnt && n < max_cyc) begin @(negedge clk); n++; end
      chk(tag, trig_cyc.size(), cnt);
   endtask

   initial begin
      m_if.m_ready = 1'b1;
      cycles(3);
      chk("rst_trig", trig_int, 0);
      chk("rst_valid", m_if.m_valid, 0);
      chk("rst_last", m_if.m_last, 0);
      chk("rst_data", m_if.m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_to", timeout_err, 0);
      rst_n = 1'b1;
      cycles(2);

      // Start with mode 00 is ignored.
      run(2'b00, 20, 0, 0);
      cycles(2);
      chk("mode00_busy", busy, 0);

      // Single, k=0, full-scale positive sample.
      out_q.delete();
      samp_q.push_back(18'h1FFFF);
      run(MODE_SINGLE, 20, 0, 0);
      cycles(1);
      chk("s1_busy_run", busy, 1);
      wait_idle("s1_idle", 200);
      cycles(5);
      chk("s1_trigs", trig_cyc.size(), 1);
      chk("s1_words", out_q.size(), 1);
      if (out_q.size() > 0) chk("s1_word", out_q[0], {1'b1, 18'h1FFFF});

      // Single, k=2: (4 + 8 - 4 + 0) / 4 = 2.
      out_q.delete();
      samp_q = '{18'd4, 18'd8, 18'h3FFFC, 18'd0};
      run(MODE_SINGLE, 20, 0, 2);
      wait_idle("s4_idle", 400);
      cycles(5);
      chk("s4_trigs", trig_cyc.size(), 4);
      chk("s4_words", out_q.size(), 1);
      if (out_q.size() > 0) chk("s4_word", out_q[0], {1'b1, 18'd2});

      // Burst of 3 at period 20.
      out_q.delete();
      samp_q = '{18'd1, 18'd2, 18'd3};
      run(MODE_BURST, 20, 3, 0);
      wait_idle("b3_idle", 400);
      cycles(5);
      chk("b3_trigs", trig_cyc.size(), 3);
      if (trig_cyc.size() == 3) begin
         chk("b3_gap0", trig_cyc[1] - trig_cyc[0], 20);
         chk("b3_gap1", trig_cyc[2] - trig_cyc[1], 20);
      end
      chk("b3_words", out_q.size(), 3);
      if (out_q.size() == 3) begin
         chk("b3_w0", out_q[0], {1'b0, 18'd1});
         chk("b3_w1", out_q[1], {1'b0, 18'd2});
         chk("b3_w2", out_q[2], {1'b1, 18'd3});
      end

      // Burst length 0 acts as 1.
      out_q.delete();
      samp_q = '{18'd7};
      run(MODE_BURST, 20, 0, 0);
      wait_idle("b0_idle", 200);
      cycles(5);
      chk("b0_trigs", trig_cyc.size(), 1);
      if (out_q.size() > 0) chk("b0_word", out_q[0], {1'b1, 18'd7});

      // Continuous at period 5 (clamped to 13) with a stalled sink.
      out_q.delete();
      m_if.m_ready = 1'b0;
      samp_q = '{18'd10, 18'd11, 18'd12, 18'd13, 18'd14};
      run(MODE_CONT, 5, 0, 0);
      wait_trigs("c_trig3", 3, 200);
      chk("c_ovr_early", overrun, 0);
      chk("c_valid", m_if.m_valid, 1);
      chk("c_hold", m_if.m_data, 10);
      chk("c_last0", m_if.m_last, 0);
      wait_trigs("c_trig4", 4, 200);
      cycles(6);
      chk("c_ovr", overrun, 1);
      if (trig_cyc.size() >= 3) begin
         chk("c_gap0", trig_cyc[1] - trig_cyc[0], 13);
         chk("c_gap1", trig_cyc[2] - trig_cyc[1], 13);
      end
      stop = 1'b1;
      cycles(1);
      stop = 1'b0;
      cycles(1);
      chk("c_stop_busy", busy, 0);
      chk("c_ovr_sticky", overrun, 1);
      m_if.m_ready = 1'b1;
      cycles(5);
      chk("c_drain", out_q.size(), 2);
      if (out_q.size() == 2) begin
         chk("c_d0", out_q[0], {1'b0, 18'd10});
         chk("c_d1", out_q[1], {1'b0, 18'd11});
      end

      // Timeout with ADC data withheld.
      out_q.delete();
      samp_q.delete();
      adc_en = 1'b0;
      run(MODE_SINGLE, 20, 0, 0);
      chk("to_ovr_clr", overrun, 0);
      cycles(1000);
      chk("to_early_err", timeout_err, 0);
      chk("to_early_busy", busy, 1);
      wait_idle("to_idle", 100);
      chk("to_err", timeout_err, 1);
      chk("to_trigs", trig_cyc.size(), 1);
      cycles(3);
      chk("to_words", out_q.size(), 0);
      adc_en = 1'b1;

      // Reset in WAIT_DATA at k=3, then a fresh run: (-1..-8)/8 = -36/8 -> -5.
      samp_q = '{18'd5, 18'd5, 18'd5, 18'd5};
      run(MODE_SINGLE, 20, 0, 3);
      wait_trigs("r_trig2", 2, 200);
      cycles(1);
      adc_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_trig", trig_int, 0);
      chk("r_valid", m_if.m_valid, 0);
      chk("r_data", m_if.m_data, 0);
      chk("r_to", timeout_err, 0);
      cycles(2);
      rst_n = 1'b1;
      samp_q.delete();
      out_q.delete();
      for (int i = 1; i <= 8; i++) samp_q.push_back(18'(-i));
      adc_en = 1'b1;
      cycles(1);
      run(MODE_SINGLE, 20, 0, 3);
      wait_idle("r_idle", 400);
      cycles(5);
      chk("r_trigs", trig_cyc.size(), 8);
      chk("r_words", out_q.size(), 1);
      if (out_q.size() > 0) chk("r_word", out_q[0], {1'b1, 18'h3FFFB});

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
